// File: rtl/fb_line_writer_if.sv
// fb_line_writer_if: pixel capture in, framebuffer write port and status out
interface fb_line_writer_if #(
  parameter int ADDRW = 14
);
  logic frameStart;
  logic lineStart;
  logic pxlValid;
  logic [11:0] pxlIn;
  logic wrEn;
  logic [ADDRW-1:0] wrAddr;
  logic [35:0] wrData;
  logic frameDone;
  logic dropErr;
  modport master(
    output frameStart, lineStart, pxlValid, pxlIn,
    input wrEn, wrAddr, wrData, frameDone, dropErr
  );
  modport slave(
    input frameStart, lineStart, pxlValid, pxlIn,
    output wrEn, wrAddr, wrData, frameDone, dropErr
  );
endinterface

// File: rtl/fb_line_writer.sv
// fb_line_writer: packs an RGB444 pixel stream into 3-pixel 36-bit framebuffer words
module fb_line_writer #(
  parameter int COLLEN = 75,
  parameter int NUMLINES = 150,
  parameter int ADDRW = 14
) (
  input logic clk,
  input logic rst,
  fb_line_writer_if.slave bus
);
  localparam int PW = $clog2(3 * COLLEN + 1);
  localparam int IW = $clog2(COLLEN);
  localparam int LW = $clog2(NUMLINES + 3);
  localparam logic [PW-1:0] P1 = PW'(COLLEN);
  localparam logic [PW-1:0] P2 = PW'(2 * COLLEN);
  localparam logic [PW-1:0] P3 = PW'(3 * COLLEN);
  localparam logic [LW-1:0] NL = LW'(NUMLINES);
  localparam logic [ADDRW-1:0] A1 = ADDRW'(COLLEN);
  localparam logic [ADDRW-1:0] A2 = ADDRW'(2 * COLLEN);
  typedef enum logic [1:0] {WAIT_FRAME, ACTIVE, FLUSH, DONE} state_t;
  function automatic logic [LW-1:0] lc_sat(input logic [LW-1:0] a);
    return a > NL ? NL : a;
  endfunction
  state_t state, state_nx;
  logic [PW-1:0] px_cnt, px_cnt_nx, j, j_nx, cnt_e;
  logic [LW-1:0] line_cnt, line_cnt_nx, lc_e, lc_adv;
  logic [ADDRW-1:0] line_base, line_base_nx, base_e;
  logic fin_frame, fin_frame_nx, pend_frame, pend_frame_nx, pend_line, pend_line_nx;
  logic wr_en, wr_en_nx, frame_done, drop_err, drop_err_nx;
  logic [ADDRW-1:0] wr_addr, wr_addr_nx;
  logic [35:0] wr_data, wr_data_nx;
  logic [11:0] lb0 [COLLEN];
  logic [11:0] lb1 [COLLEN];
  logic start, take, pf, pl, fin, we0, we1;
  logic [IW-1:0] rd_idx, st_idx;
  // a start in the same cycle as a pixel opens the new line before the pixel lands
  assign start = bus.frameStart | bus.lineStart;
  assign cnt_e = start ? '0 : px_cnt;
  assign lc_e = bus.frameStart ? '0 : bus.lineStart ? lc_sat(line_cnt + LW'(1)) : line_cnt;
  assign base_e = bus.frameStart ? '0 : bus.lineStart ? line_base + A1 : line_base;
  assign take = bus.pxlValid && lc_e < NL && cnt_e < P3;
  assign pf = pend_frame | bus.frameStart;
  assign pl = pend_line | bus.lineStart;
  assign fin = fin_frame | pf;
  assign lc_adv = lc_sat(line_cnt + (pl ? LW'(2) : LW'(1)));
  assign st_idx = IW'(cnt_e < P1 ? cnt_e : cnt_e - P1);
  assign rd_idx = state == FLUSH ? IW'(j) : IW'(cnt_e - P2);
  always_comb begin
    state_nx = state;
    px_cnt_nx = px_cnt;
    j_nx = j;
    line_cnt_nx = line_cnt;
    line_base_nx = line_base;
    fin_frame_nx = fin_frame;
    pend_frame_nx = pend_frame;
    pend_line_nx = pend_line;
    wr_en_nx = 1'b0;
    wr_addr_nx = wr_addr;
    wr_data_nx = wr_data;
    drop_err_nx = drop_err;
    we0 = 1'b0;
    we1 = 1'b0;
    if (state == WAIT_FRAME) begin
      if (bus.frameStart) begin
        state_nx = ACTIVE;
        px_cnt_nx = '0;
        line_cnt_nx = '0;
        line_base_nx = '0;
      end
    end else if (state == FLUSH) begin
      wr_en_nx = 1'b1;
      wr_addr_nx = line_base + ADDRW'(j);
      wr_data_nx = {j < px_cnt ? lb0[rd_idx] : 12'h0, j + P1 < px_cnt ? lb1[rd_idx] : 12'h0, 12'h0};
      drop_err_nx = drop_err | bus.pxlValid;
      pend_frame_nx = pf;
      pend_line_nx = pl;
      j_nx = j + PW'(1);
      if (j == P1 - PW'(1)) begin
        state_nx = fin ? DONE : ACTIVE;
        px_cnt_nx = '0;
        line_cnt_nx = fin ? '0 : lc_adv;
        line_base_nx = fin ? '0 : line_base + (pl ? A2 : A1);
      end
    end else if (start && px_cnt != '0 && px_cnt != P3) begin
      state_nx = FLUSH;
      j_nx = px_cnt >= P2 ? px_cnt - P2 : '0;
      fin_frame_nx = bus.frameStart;
      pend_frame_nx = 1'b0;
      pend_line_nx = 1'b0;
      drop_err_nx = drop_err | bus.pxlValid;
    end else begin
      state_nx = bus.frameStart ? DONE : ACTIVE;
      px_cnt_nx = take ? cnt_e + PW'(1) : cnt_e;
      line_cnt_nx = lc_e;
      line_base_nx = base_e;
      we0 = take && cnt_e < P1;
      we1 = take && cnt_e >= P1 && cnt_e < P2;
      if (take && cnt_e >= P2) begin
        wr_en_nx = 1'b1;
        wr_addr_nx = base_e + ADDRW'(cnt_e - P2);
        wr_data_nx = {lb0[rd_idx], lb1[rd_idx], bus.pxlIn};
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= WAIT_FRAME;
      px_cnt <= '0;
      j <= '0;
      line_cnt <= '0;
      line_base <= '0;
      fin_frame <= 1'b0;
      pend_frame <= 1'b0;
      pend_line <= 1'b0;
      wr_en <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      frame_done <= 1'b0;
      drop_err <= 1'b0;
    end else begin
      state <= state_nx;
      px_cnt <= px_cnt_nx;
      j <= j_nx;
      line_cnt <= line_cnt_nx;
      line_base <= line_base_nx;
      fin_frame <= fin_frame_nx;
      pend_frame <= pend_frame_nx;
      pend_line <= pend_line_nx;
      wr_en <= wr_en_nx;
      wr_addr <= wr_addr_nx;
      wr_data <= wr_data_nx;
      frame_done <= state == DONE;
      drop_err <= drop_err_nx;
    end
  end
  always_ff @(posedge clk) begin
    if (we0) lb0[st_idx] <= bus.pxlIn;
    if (we1) lb1[st_idx] <= bus.pxlIn;
  end
  assign bus.wrEn = wr_en;
  assign bus.wrAddr = wr_addr;
  assign bus.wrData = wr_data;
  assign bus.frameDone = frame_done;
  assign bus.dropErr = drop_err;
endmodule

// File: tb/tb_fb_line_writer.sv
// tb_fb_line_writer: directed and random pixel streams against a line-array reference model
module tb_fb_line_writer;
  localparam int C = 75;
  localparam int NLINES = 150;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  fb_line_writer_if #(.ADDRW(14)) bus();
  fb_line_writer dut(.clk(clk), .rst(rst), .bus(bus.slave));
  int total = 0, bad = 0;
  // reference model: whole-line pixel array, absolute addresses, flush as a busy countdown
  logic [11:0] row [3*C];
  bit m_run;
  int busy, fl_j, pc, lc;
  bit fin, pf, pl, dpend;
  bit e_wr, e_done, e_drop;
  int e_addr;
  logic [35:0] e_data;
  logic [35:0] obs [16384];
  int nwr = 0, last_addr = -1, max_addr = -1, fd_cnt = 0;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic model(input bit fs, input bit ls, input bit pv, input logic [11:0] px);
    e_wr = 0;
    e_done = dpend;
    dpend = 0;
    if (!m_run) begin
      if (fs) begin m_run = 1; pc = 0; lc = 0; end
    end else if (busy > 0) begin
      e_wr = 1;
      e_addr = lc * C + fl_j;
      e_data = {fl_j < pc ? row[fl_j] : 12'h0, fl_j + C < pc ? row[fl_j + C] : 12'h0, 12'h0};
      fl_j++;
      busy--;
      if (pv) e_drop = 1;
      if (fs) pf = 1; else if (ls) pl = 1;
      if (busy == 0) begin
        if (fin || pf) begin lc = 0; dpend = 1; end
        else lc += pl ? 2 : 1;
        pc = 0; pf = 0; pl = 0;
      end
    end else if ((fs || ls) && pc != 0 && pc != 3 * C) begin
      fl_j = pc >= 2 * C ? pc - 2 * C : 0;
      busy = C - fl_j;
      fin = fs; pf = 0; pl = 0;
      if (pv) e_drop = 1;
    end else begin
      if (fs) begin lc = 0; pc = 0; dpend = 1; end
      else if (ls) begin lc++; pc = 0; end
      if (pv && lc < NLINES && pc < 3 * C) begin
        row[pc] = px;
        if (pc >= 2 * C) begin
          e_wr = 1;
          e_addr = lc * C + pc - 2 * C;
          e_data = {row[pc - 2 * C], row[pc - C], px};
        end
        pc++;
      end
    end
  endtask
  task automatic step(input bit fs, input bit ls, input bit pv, input logic [11:0] px);
    bus.frameStart = fs;
    bus.lineStart = ls;
    bus.pxlValid = pv;
    bus.pxlIn = px;
    model(fs, ls, pv, px);
    @(posedge clk);
    #1;
    check("wrEn", bus.wrEn, e_wr);
    if (e_wr) begin
      check("wrAddr", bus.wrAddr, e_addr);
      check("wrData", bus.wrData, e_data);
    end
    check("frameDone", bus.frameDone, e_done);
    check("dropErr", bus.dropErr, e_drop);
    if (bus.wrEn) begin
      obs[bus.wrAddr] = bus.wrData;
      nwr++;
      last_addr = int'(bus.wrAddr);
      if (int'(bus.wrAddr) > max_addr) max_addr = int'(bus.wrAddr);
    end
    if (bus.frameDone) fd_cnt++;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    bus.frameStart = 0; bus.lineStart = 0; bus.pxlValid = 0; bus.pxlIn = '0;
    m_run = 0; busy = 0; pc = 0; lc = 0; dpend = 0; e_drop = 0; fin = 0; pf = 0; pl = 0;
    @(posedge clk);
    #1;
    check("rst_wrEn", bus.wrEn, 0);
    check("rst_wrAddr", bus.wrAddr, 0);
    check("rst_wrData", bus.wrData, 0);
    check("rst_frameDone", bus.frameDone, 0);
    check("rst_dropErr", bus.dropErr, 0);
    rst = 1'b0;
  endtask
  task automatic pixels(input int n);
    for (int x = 0; x < n; x++) step(0, 0, 1, 12'(x));
  endtask
  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 0, 0, 12'h0);
  endtask
  initial begin
    int n0;
    do_reset();
    pixels(10);
    check("no_frame_writes", nwr, 0);
    step(1, 0, 0, 0);
    pixels(225);
    check("line0_cnt", nwr, 75);
    check("line0_a0", obs[0], {12'h000, 12'h04B, 12'h096});
    check("line0_a74", obs[74], {12'h04A, 12'h095, 12'h0E0});
    step(0, 1, 0, 0);
    idle(3);
    check("no_flush_full", nwr, 75);
    step(1, 0, 0, 0);
    pixels(224);
    step(0, 1, 0, 0);
    idle(2);
    check("short_flush_a74", obs[74], {12'h04A, 12'h095, 12'h000});
    pixels(151);
    check("next_line_addr", last_addr, 75);
    step(1, 0, 0, 0);
    idle(80);
    fd_cnt = 0;
    pixels(100);
    step(1, 0, 0, 0);
    idle(80);
    check("flush_a0", obs[0], {12'h000, 12'h04B, 12'h000});
    check("flush_a25", obs[25], {12'h019, 12'h000, 12'h000});
    check("frame_done_once", fd_cnt, 1);
    pixels(151);
    check("new_frame_addr", last_addr, 0);
    step(1, 0, 0, 0);
    idle(80);
    n0 = nwr;
    max_addr = -1;
    for (int l = 0; l < 152; l++) begin
      pixels(225);
      step(0, 1, 0, 0);
    end
    check("frame_writes", nwr - n0, NLINES * C);
    check("max_addr", max_addr, NLINES * C - 1);
    step(1, 0, 0, 0);
    pixels(50);
    step(0, 1, 0, 0);
    idle(10);
    step(0, 0, 1, 12'hABC);
    idle(80);
    check("drop_sticky", bus.dropErr, 1);
    step(1, 0, 0, 0);
    pixels(30);
    step(0, 1, 0, 0);
    idle(5);
    do_reset();
    n0 = nwr;
    pixels(20);
    check("post_rst_nowrite", nwr - n0, 0);
    step(1, 0, 0, 0);
    pixels(151);
    check("post_rst_count", nwr - n0, 1);
    check("post_rst_addr", last_addr, 0);
    for (int k = 0; k < 3000; k++)
      step($urandom_range(299) == 0, $urandom_range(119) == 0, $urandom_range(9) < 7, 12'($urandom));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fb_line_writer.md
Name: fb_line_writer

Overview:
- Write-side counterpart of the HDMI framebuffer reader. It takes the captured handheld LCD pixel stream (12-bit RGB444, one pixel per strobe) and packs it into the 36-bit, 3-pixel-per-word framebuffer layout that the reader scans.
- Screen column x of line L is stored at address L*COLLEN + (x mod COLLEN), in slice x div COLLEN:
  - slice 0 = bits [35:24]
  - slice 1 = bits [23:12]
  - slice 2 = bits [11:0]
- The block sits between the LCD capture logic and the BRAM write port, in the pixel clock domain.

Parameters:
- COLLEN, 75, words per framebuffer line (line width is 3*COLLEN pixels).
- NUMLINES, 150, framebuffer lines stored per frame; later lines are discarded.
- ADDRW, 14, framebuffer address width.

Ports:
- clk  in  1  pixel clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- frameStart  in  1  one-cycle pulse; a new frame begins (implies lineStart).
- lineStart  in  1  one-cycle pulse; a new line begins.
- pxlValid  in  1  pxlIn holds a valid pixel this cycle.
- pxlIn  in  12  pixel {R[3:0],G[3:0],B[3:0]}.
- wrEn  out  1  framebuffer write strobe, one word per cycle, no backpressure.
- wrAddr  out  ADDRW  framebuffer word address.
- wrData  out  36  packed word {slice0, slice1, slice2}.
- frameDone  out  1  one-cycle pulse after the final write of a frame.
- dropErr  out  1  sticky; set when a pixel is dropped during FLUSH. Cleared only by rst.

Behaviour:
- Reset:
  - wrEn=0, wrAddr=0, wrData=0, frameDone=0, dropErr=0.
  - State WAIT_FRAME; pixel counter pxCnt=0; line counter lineCnt=0; lineBase=0.
  - A reset mid-FLUSH aborts the flush; wrEn=0 on the cycle after rst is sampled.
- Storage: two internal line arrays, lb0 and lb1, each COLLEN x 12 bit, holding slices 0 and 1 of the current line. Both arrays are readable in the same cycle.
- States: WAIT_FRAME, ACTIVE, FLUSH, DONE.
- WAIT_FRAME:
  - pxlValid and lineStart are ignored.
  - frameStart -> ACTIVE with lineCnt=0, lineBase=0, pxCnt=0.
- ACTIVE, on each pxlValid with line accepted (lineCnt < NUMLINES):
  - pxCnt < COLLEN: store to lb0[pxCnt].
  - COLLEN <= pxCnt < 2*COLLEN: store to lb1[pxCnt-COLLEN].
  - 2*COLLEN <= pxCnt < 3*COLLEN: with i = pxCnt-2*COLLEN, on the next cycle drive wrEn=1, wrAddr=lineBase+i, wrData={lb0[i], lb1[i], pxlIn}. Write latency is 1 cycle.
  - pxCnt >= 3*COLLEN: pixel ignored; pxCnt saturates at 3*COLLEN.
  - pxCnt increments on every accepted pixel.
- Lines with lineCnt >= NUMLINES: all pixels are ignored and no writes occur.
- lineStart in ACTIVE:
  - If pxCnt = 0 or pxCnt = 3*COLLEN: no flush needed. Set lineBase += COLLEN, lineCnt += 1, pxCnt=0 in the same cycle.
  - Else -> FLUSH.
- FLUSH:
  - Issues one write per cycle for indices j = (pxCnt >= 2*COLLEN ? pxCnt-2*COLLEN : 0) through COLLEN-1.
  - Data is {lb0[j], lb1[j], 0}. Slice 0 is forced to 0 if j >= pxCnt; slice 1 is forced to 0 if j+COLLEN >= pxCnt.
  - After the last write, apply the line advance and return to ACTIVE.
  - pxlValid during FLUSH: the pixel is dropped and dropErr is set.
  - Note: no pixel has been stored for pxCnt==0, so a flush never occurs with pxCnt=0.
- frameStart in ACTIVE:
  - Flush exactly as for lineStart if needed, then go to DONE.
  - DONE lasts one cycle: frameDone=1, then lineCnt=0, lineBase=0, pxCnt=0 -> ACTIVE.
- frameStart and lineStart in the same cycle: treated as frameStart only.
- lineStart or frameStart in the same cycle as pxlValid: the start is processed first, and the pixel belongs to the new line. If a flush is required, that pixel is dropped and dropErr is set.
- frameStart or lineStart arriving during FLUSH: latched, and acted on after the flush completes. A frameStart overrides a pending lineStart.
- Address arithmetic: lineBase is ADDRW bits. The maximum address is NUMLINES*COLLEN-1 = 11249, so there is no wrap at the defaults.

Test Plan:
- frameStart, then 225 pixels with pxlIn = x -> 75 writes:
  - wrAddr 0..74, each 1 cycle after pixels 150..224.
  - wrAddr 0 data = {000, 04B, 096}; wrAddr 74 data = {04A, 095, 0E0}.
  - No flush on the next lineStart.
- 224 pixels, then lineStart -> 74 inline writes, then a 1-cycle FLUSH writing addr 74 data {04A, 095, 000}. The next line's pixel 150 writes addr 75.
- 100 pixels, then frameStart -> 75 flush writes at addr 0..74 on consecutive cycles:
  - addr 0 data = {000, 04B, 000}.
  - addr 25 data = {019, 000, 000}.
  - Then frameDone pulses once, and the next line's first write goes to addr 0.
- 152 full lines in one frame -> lines 0..149 are written (last addr 11249); lines 150 and 151 produce no wrEn.
- pxlValid asserted in the middle of a FLUSH -> the pixel is not written and dropErr=1, staying 1 until rst.
- rst asserted during FLUSH -> wrEn=0 next cycle and all outputs at reset values. Pixels with no frameStart produce no writes; after frameStart, the first write goes to addr 0.
